// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall/bubble performance counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_skid_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CTRL_W-1:0] s_ctrl,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [1:0]        occupancy
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_s_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_s_fire;
    logic              w_m_fire;
    logic              w_load_main_s;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign s_ready   = r_s_ready;
    assign m_valid   = (r_state != EMPTY);
    assign m_data    = r_main_data;
    // Bubbles never carry control, so RegWrite/MemWrite cannot leak downstream
    assign m_ctrl    = m_valid ? r_main_ctrl : '0;
    assign occupancy = r_state;
    assign w_s_fire  = s_valid & r_s_ready;
    assign w_m_fire  = m_valid & m_ready;

    always_comb begin
        w_next           = r_state;
        w_load_main_s    = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next        = w_s_fire ? ONE : EMPTY;
                w_load_main_s = w_s_fire;
            end
            ONE: begin
                w_next        = w_s_fire ? (w_m_fire ? ONE : FULL) : (w_m_fire ? EMPTY : ONE);
                w_load_main_s = w_s_fire & w_m_fire;
                w_load_skid   = w_s_fire & ~w_m_fire;
            end
            FULL: begin
                w_next           = w_m_fire ? ONE : FULL;
                w_load_main_skid = w_m_fire;
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next           = EMPTY;
            w_load_main_s    = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_s_ready   <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state   <= w_next;
            r_s_ready <= (w_next != FULL);
            if (w_load_main_s) begin
                r_main_data <= s_data;
                r_main_ctrl <= s_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= s_data;
                r_skid_ctrl <= s_ctrl;
            end
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (m_valid && !m_ready && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!m_valid && !flush && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: directed checks of reset, streaming, back-pressure, flush and simultaneous fire.
module tb_ex_mem_skid_reg;
    localparam int DATA_W = 160;
    localparam int CTRL_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic [CTRL_W-1:0] s_ctrl = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [1:0]        occupancy;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    ex_mem_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ctrl(s_ctrl),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ctrl(m_ctrl),
        .occupancy(occupancy)
`ifdef EX_MEM_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] pay(input logic [31:0] alu);
        return {32'hC0DE_0000 + alu, 96'h0, alu};
    endfunction

    function automatic logic [CTRL_W-1:0] ctl(input logic [4:0] rd, input logic [2:0] rs, input logic rw, input logic mw);
        return {rd, rs, rw, mw};
    endfunction

    task automatic offer(input logic [31:0] alu, input logic [CTRL_W-1:0] c);
        s_valid = 1'b1;
        s_data  = pay(alu);
        s_ctrl  = c;
    endtask

    initial begin
        // Reset with s_valid asserted: nothing may be captured
        offer(32'hDEAD, ctl(5'd3, 3'd1, 1'b1, 1'b1));
        tick();
        tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_ctrl", m_ctrl, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;
        s_valid = 1'b0;

        // Streaming with m_ready high
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h10 + i, ctl(5'(i + 1), 3'(i), 1'b1, 1'b0));
            tick();
            chk("stream_valid", m_valid, 1);
            chk("stream_data", m_data, pay(32'h10 + i));
            chk("stream_ctrl", m_ctrl, ctl(5'(i + 1), 3'(i), 1'b1, 1'b0));
            chk("stream_s_ready", s_ready, 1);
        end
        s_valid = 1'b0;
        tick();
        chk("drain_valid", m_valid, 0);
        chk("bubble_ctrl", m_ctrl, 0);
        chk("drain_occ", occupancy, 0);

        // Back-pressure: A to main, B to skid, C held off
        m_ready = 1'b0;
        offer(32'hA, ctl(5'd10, 3'd2, 1'b1, 1'b0));
        tick();
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_data", m_data, pay(32'hA));
        offer(32'hB, ctl(5'd11, 3'd3, 1'b0, 1'b1));
        tick();
        chk("bp_full_occ", occupancy, 2);
        chk("bp_full_s_ready", s_ready, 0);
        offer(32'hC, ctl(5'd12, 3'd4, 1'b1, 1'b1));
        tick();
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_data", m_data, pay(32'hA));
        chk("bp_hold_ctrl", m_ctrl, ctl(5'd10, 3'd2, 1'b1, 1'b0));
        m_ready = 1'b1;
        tick();
        chk("bp_b_data", m_data, pay(32'hB));
        chk("bp_b_ctrl", m_ctrl, ctl(5'd11, 3'd3, 1'b0, 1'b1));
        chk("bp_b_occ", occupancy, 1);
        chk("bp_b_s_ready", s_ready, 1);
        tick();
        chk("bp_c_data", m_data, pay(32'hC));
        chk("bp_c_occ", occupancy, 1);
        s_valid = 1'b0;
        tick();
        chk("bp_empty", m_valid, 0);

        // Flush while FULL, with a RegWrite entry offered alongside
        m_ready = 1'b0;
        offer(32'hD, ctl(5'd1, 3'd0, 1'b1, 1'b0));
        tick();
        offer(32'hE, ctl(5'd2, 3'd0, 1'b1, 1'b0));
        tick();
        chk("fl_pre_occ", occupancy, 2);
        offer(32'hF, ctl(5'd5, 3'd0, 1'b1, 1'b0));
        flush = 1'b1;
        tick();
        chk("fl_m_valid", m_valid, 0);
        chk("fl_m_ctrl", m_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_s_ready", s_ready, 1);
        flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("fl_no_emit", m_valid, 0);

        // Simultaneous s_fire and m_fire in ONE
        m_ready = 1'b0;
        offer(32'h61, ctl(5'd7, 3'd1, 1'b1, 1'b0));
        tick();
        chk("sim_g_data", m_data, pay(32'h61));
        m_ready = 1'b1;
        offer(32'h62, ctl(5'd8, 3'd2, 1'b0, 1'b1));
        tick();
        chk("sim_h_data", m_data, pay(32'h62));
        chk("sim_h_ctrl", m_ctrl, ctl(5'd8, 3'd2, 1'b0, 1'b1));
        chk("sim_occ", occupancy, 1);
        s_valid = 1'b0;
        tick();
        chk("sim_empty", occupancy, 0);

`ifdef EX_MEM_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perf_rst", stall_cnt, 0);
        m_ready = 1'b0;
        offer(32'h77, ctl(5'd9, 3'd0, 1'b1, 1'b0));
        tick();
        s_valid = 1'b0;
        chk("perf_start", stall_cnt, 0);
        for (int i = 0; i < 7; i++) tick();
        chk("perf_stall7", stall_cnt, 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
